// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline-stage register with a valid/ready handshake. It is used as
//   the IF/ID, ID/EX, EX/MEM and MEM/WB stage register. With SKID=1 it holds up
//   to two entries, and in_ready comes from a register. With SKID=0 it holds a
//   single entry, and in_ready = !out_valid | out_ready.
//
//   Handshake: a transfer happens on a rising CLK edge when valid and ready are
//   both high on that side (push = in_valid & in_ready, pop = out_valid &
//   out_ready). The producer must hold valid/ctrl/data stable until it sees
//   ready. Entries leave in strict FIFO order.
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   synchronous active-low reset
//   flush      in   kill all held entries at this edge (a same-cycle push is dropped)
//   in_valid   in   upstream entry valid
//   in_ready   out  stage accepts this cycle
//   in_ctrl    in   control field, CTRL_W bits
//   in_data    in   data field, DATA_W bits
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts this cycle
//   out_ctrl   out  head control field, forced to 0 when out_valid=0
//   out_data   out  head data field
//   occupancy  out  entries held (0..2); this is also the FSM state encoding
//   bp_cnt     out  saturating count of cycles with out_valid & !out_ready

module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cnt
);

  // The encoding equals the number of held entries. This lets occupancy
  // expose the FSM state directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BP_MAX = '1;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    bp_cnt_q, bp_cnt_d;
  logic                push, pop;

  assign out_valid = (state_q != ST_EMPTY);
  // With SKID=1, in_ready comes only from a register. This breaks the
  // combinational path from out_ready to upstream.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign bp_cnt    = bp_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (push) begin
          // Only reachable with SKID=1. With SKID=0, in_ready implies pop
          // when the stage is occupied.
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = ST_FULL;
        end else if (pop) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush: every entry becomes a bubble with zero ctrl. Data registers keep
    // their old contents, so any same-cycle push is dropped.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end
  end

  always_comb begin
    in_ready_d = (state_d != ST_FULL);
    bp_cnt_d   = bp_cnt_q;
    if (out_valid && !out_ready && (bp_cnt_q != BP_MAX)) begin
      bp_cnt_d = bp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      bp_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      bp_cnt_q    <= bp_cnt_d;
    end
  end

endmodule
